// File: rtl/systolic_job_seq_if.sv
// systolic_job_seq_if: job, array-feed and result bus of the systolic job sequencer.
// master modport: job source plus array side (drives valid, a, b, c_arr).
// slave modport : sequencer side (drives ready, sys_clr, sys_en, lanes, c, done, busy).
// valid/ready   : job handshake; a/b carry the operand matrices, W bits per element
// sys_clr/sys_en: accumulator clear and advance enable for the array
// a_lanes/b_lanes: skewed operand streams, one W-bit lane per array row/column
// c_arr         : live array result; c: captured result; done: capture pulse; busy: job in flight
interface systolic_job_seq_if #(
    parameter int W = 32,
    parameter int N = 3
);
    logic                 valid;
    logic                 ready;
    logic [W*N*N-1:0]     a;
    logic [W*N*N-1:0]     b;
    logic                 sys_clr;
    logic                 sys_en;
    logic [W*N-1:0]       a_lanes;
    logic [W*N-1:0]       b_lanes;
    logic [2*W*N*N-1:0]   c_arr;
    logic [2*W*N*N-1:0]   c;
    logic                 done;
    logic                 busy;
    modport master (
        output valid, a, b, c_arr,
        input  ready, sys_clr, sys_en, a_lanes, b_lanes, c, done, busy
    );
    modport slave (
        input  valid, a, b, c_arr,
        output ready, sys_clr, sys_en, a_lanes, b_lanes, c, done, busy
    );
endinterface

// File: rtl/systolic_job_seq.sv
// systolic_job_seq: job sequencer for an NxN output-stationary systolic multiplier.
// Latches one A/B pair per job, clears the array, streams skewed operands, drains
// the pipeline, captures the product matrix and pulses done.
// i_clk : clock, rising edge
// i_rst : synchronous active-high reset, aborts any job in flight
// bus   : slave side of systolic_job_seq_if (handshake, array feed, result capture)
module systolic_job_seq #(
    parameter int W         = 32,
    parameter int N         = 3,
    parameter int DRAIN_CYC = N
) (
    input  logic               i_clk,
    input  logic               i_rst,
    systolic_job_seq_if.slave  bus
);
    localparam int FEED_LEN = 2 * N - 1;
    localparam int CW       = $clog2(FEED_LEN + DRAIN_CYC) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           st, st_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [W*N*N-1:0] a_q, b_q;
    logic [W*N-1:0]   a_n, b_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    // The counter restarts on every state change and holds at 0 while idle,
    // so it never wraps.
    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = bus.valid ? CLEAR : IDLE;
            CLEAR:   st_n = FEED;
            FEED:    st_n = (cnt == CW'(FEED_LEN - 1)) ? DRAIN : FEED;
            DRAIN:   st_n = (cnt == CW'(DRAIN_CYC - 1)) ? DONE : DRAIN;
            default: st_n = IDLE;
        endcase
        cnt_n = (st_n != st || st == IDLE) ? '0 : cnt + 1'b1;
    end

    // Skew: at feed step t, row lane i carries A[i][t-i] and column lane j
    // carries B[t-j][j]. Decoded from next state/count so the registered lanes
    // line up with the state they belong to.
    always_comb begin
        a_n = '0;
        b_n = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (st_n == FEED && cnt_n == CW'(i + k)) begin
                    a_n[i*W +: W] = a_q[(i*N+k)*W +: W];
                    b_n[i*W +: W] = b_q[(k*N+i)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q         <= '0;
            b_q         <= '0;
            bus.c       <= '0;
            bus.sys_clr <= 1'b0;
            bus.sys_en  <= 1'b0;
            bus.a_lanes <= '0;
            bus.b_lanes <= '0;
        end else begin
            if (st == IDLE && bus.valid) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (st_n == DONE)
                bus.c <= bus.c_arr;
            bus.sys_clr <= st_n == CLEAR;
            bus.sys_en  <= st_n == FEED || st_n == DRAIN;
            bus.a_lanes <= a_n;
            bus.b_lanes <= b_n;
        end
    end

    assign bus.ready = st == IDLE;
    assign bus.busy  = st != IDLE;
    assign bus.done  = st == DONE;
endmodule

// File: tb/tb_systolic_job_seq.sv
// tb_systolic_job_seq: randomized scoreboard bench for systolic_job_seq with a behavioural array model.
module tb_systolic_job_seq;
    localparam int W   = 32;
    localparam int N   = 3;
    localparam int D   = 3;
    localparam int AW  = W * N * N;
    localparam int CWD = 2 * W * N * N;
    localparam int LAT = 1 + (2 * N - 1) + D + 1;

    typedef struct {
        logic [CWD-1:0] c;
        int             acc_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;

    systolic_job_seq_if #(.W(W), .N(N)) b1 (), b2 ();

    systolic_job_seq #(.W(W), .N(N)) dut (.i_clk(clk), .i_rst(rst), .bus(b1));
    systolic_job_seq #(.W(W), .N(N), .DRAIN_CYC(5)) dut5 (.i_clk(clk), .i_rst(rst), .bus(b2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array driven by the sequencer's lanes.
    logic [2*W-1:0] acc [N][N];
    logic [W-1:0]   ar  [N][N];
    logic [W-1:0]   br  [N][N];

    function automatic logic [W-1:0] ain(input int i, input int j);
        if (j == 0) return b1.a_lanes[i*W +: W];
        return ar[i][j-1];
    endfunction

    function automatic logic [W-1:0] bin(input int i, input int j);
        if (i == 0) return b1.b_lanes[j*W +: W];
        return br[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || b1.sys_clr) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else if (b1.sys_en) begin
                    acc[i][j] <= acc[i][j] + {{W{1'b0}}, ain(i, j)} * {{W{1'b0}}, bin(i, j)};
                    ar[i][j]  <= ain(i, j);
                    br[i][j]  <= bin(i, j);
                end
            end
        end
    end

    always_comb begin
        b1.c_arr = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                b1.c_arr[(i*N+j)*2*W +: 2*W] = acc[i][j];
    end

    task automatic chk(input string nm, input logic [CWD-1:0] got, input logic [CWD-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    endtask

    function automatic logic [CWD-1:0] matmul(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [CWD-1:0] res;
        logic [2*W-1:0] s, x, y;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = '0;
                for (int k = 0; k < N; k++) begin
                    x = {{W{1'b0}}, a[(r*N+k)*W +: W]};
                    y = {{W{1'b0}}, b[(k*N+c)*W +: W]};
                    s = s + x * y;
                end
                res[(r*N+c)*2*W +: 2*W] = s;
            end
        end
        return res;
    endfunction

    // Lane l at feed step t: A[l][t-l] for rows, B[t-l][l] for columns.
    function automatic logic [W*N-1:0] lanes_exp(input logic [AW-1:0] m, input int t, input bit col);
        logic [W*N-1:0] o;
        int idx;
        o = '0;
        for (int l = 0; l < N; l++) begin
            idx = t - l;
            if (idx >= 0 && idx < N)
                o[l*W +: W] = col ? m[(idx*N+l)*W +: W] : m[(l*N+idx)*W +: W];
        end
        return o;
    endfunction

    function automatic logic [AW-1:0] rnd_m();
        logic [AW-1:0] m;
        for (int i = 0; i < N * N; i++) m[i*W +: W] = $urandom;
        return m;
    endfunction

    // Reference model state: one job in flight, timed in cycles since accept.
    exp_t           sb[$];
    bit             act = 1'b0;
    int             acc_c = 0;
    int             last_acc_c = 0;
    int             last_done_c = 0;
    logic [AW-1:0]  ja, jb;
    logic [CWD-1:0] jc;
    logic [CWD-1:0] c_hold = '0;

    task automatic model_step();
        int k;
        bit inj;
        k   = act ? cyc - acc_c : 0;
        inj = act && k >= 1 && k <= LAT;
        chk("ready", b1.ready, !inj);
        chk("busy", b1.busy, inj);
        chk("sys_clr", b1.sys_clr, inj && k == 1);
        chk("sys_en", b1.sys_en, inj && k >= 2 && k <= LAT - 1);
        chk("done", b1.done, inj && k == LAT);
        chk("a_lanes", b1.a_lanes, (inj && k >= 2 && k <= 2 * N) ? lanes_exp(ja, k - 2, 1'b0) : '0);
        chk("b_lanes", b1.b_lanes, (inj && k >= 2 && k <= 2 * N) ? lanes_exp(jb, k - 2, 1'b1) : '0);
        if (inj && k == LAT) begin
            c_hold = jc;
            act    = 1'b0;
        end
        chk("c_hold", b1.c, c_hold);
        if (rst) begin
            act    = 1'b0;
            c_hold = '0;
            sb.delete();
        end else if (!inj && b1.valid) begin
            act        = 1'b1;
            acc_c      = cyc;
            last_acc_c = cyc;
            ja         = b1.a;
            jb         = b1.b;
            jc         = matmul(ja, jb);
            sb.push_back('{c: jc, acc_c: cyc});
        end
    endtask

    task automatic sb_step();
        exp_t e;
        if (b1.done) begin
            if (sb.size() == 0) chk("sb_nonempty_on_done", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("latency", cyc - e.acc_c, LAT);
                chk("result", b1.c, e.c);
                last_done_c = cyc;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_on) model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) sb_step();
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b1.ready && n < 40);
        chk("ready_wait", b1.ready, 1'b1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b);
        b1.a     = a;
        b1.b     = b;
        b1.valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        b1.valid = 1'b0;
        b1.a     = rnd_m();
        b1.b     = rnd_m();
    endtask

    logic [AW-1:0]  ma, mb;
    logic [CWD-1:0] pat2;
    int             en_cnt, done_k, n;

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        b1.valid = 1'b0; b1.a = '0; b1.b = '0;
        b2.valid = 1'b0; b2.a = '0; b2.b = '0;
        for (int i = 0; i < CWD / 32; i++) pat2[i*32 +: 32] = $urandom;
        b2.c_arr = pat2;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        step(2);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[(r*N+c)*W +: W] = (r == c) ? W'(1) : W'(0);
                mb[(r*N+c)*W +: W] = W'(r * 3 + c + 1);
            end
        send(ma, mb);
        step(LAT);

        for (int i = 0; i < N * N; i++) begin
            ma[i*W +: W] = W'(2);
            mb[i*W +: W] = W'(2);
        end
        send(ma, mb);
        step(LAT);

        b1.a = rnd_m(); b1.b = rnd_m(); b1.valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        b1.a = rnd_m(); b1.b = rnd_m();
        wait_ready();
        @(posedge clk);
        #1;
        b1.valid = 1'b0;
        chk("b2b_accept_gap", last_acc_c - last_done_c, 1);
        step(LAT);

        send(rnd_m(), rnd_m());
        step(3);
        b1.valid = 1'b1; b1.a = rnd_m(); b1.b = rnd_m();
        step(1);
        b1.valid = 1'b0;
        step(2);
        b1.valid = 1'b1;
        step(1);
        b1.valid = 1'b0;
        step(3);

        send(rnd_m(), rnd_m());
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);

        for (int j = 0; j < 12; j++) begin
            if (j % 3 == 0) begin
                for (int i = 0; i < N * N; i++) begin
                    ma[i*W +: W] = W'($urandom_range(0, 7));
                    mb[i*W +: W] = W'($urandom_range(0, 7));
                end
                send(ma, mb);
            end else send(rnd_m(), rnd_m());
            step($urandom_range(0, 12));
        end
        step(LAT + 2);

        b2.a = rnd_m(); b2.b = rnd_m(); b2.valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b2.ready && n < 40);
        chk("d5_ready_wait", b2.ready, 1'b1);
        @(posedge clk);
        #1;
        b2.valid = 1'b0;
        en_cnt = 0;
        done_k = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (b2.sys_en) en_cnt++;
            if (b2.done && done_k == 0) done_k = k;
        end
        chk("d5_latency", done_k, 12);
        chk("d5_en_cycles", en_cnt, 10);
        chk("d5_capture", b2.c, pat2);
        chk("d5_idle", b2.ready, 1'b1);

        step(3);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
